data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
//  Parametrised single-port data memory with request/ready handshake, byte-lane writes and
//  programmable wait states. Serves the MEM stage; wait states model slower memory without core change.
//  One transaction in flight. Read data returns with a one-cycle rvalid pulse.
// PARAMETERS
//  DATA_WIDTH   16    word width in bits; must be a multiple of 8
//  ADDR_WIDTH   12    word-address width
//  DEPTH        4096  number of words; 1 <= DEPTH <= 2**ADDR_WIDTH
//  WAIT_STATES  0     extra busy cycles per access, 0..15
//  (local) BE_WIDTH = DATA_WIDTH/8
// PORTS
//  clock    in   1           single clock; all state changes on posedge
//  reset    in   1           synchronous, active-high
//  req      in   1           transaction request; accepted on an edge where req && ready
//  RW       in   1           1 = read, 0 = write; sampled at acceptance
//  Address  in   ADDR_WIDTH  word address; sampled at acceptance
//  wdata    in   DATA_WIDTH  write data; sampled at acceptance
//  be       in   BE_WIDTH    byte enables, bit i -> wdata[8i+7:8i]; sampled at acceptance
//  ready    out  1           high only in IDLE; controller can accept a request
//  rvalid   out  1           one-cycle pulse; rdata valid for a completed read
//  rdata    out  DATA_WIDTH  read data, registered; holds last read value until the next read completes
//  err      out  1           range error flag, pulses with completion (DMEM_RANGE_CHK_EN only; else 0)
// BEHAVIOUR
//  Reset: state=IDLE, ready=1, rvalid=0, rdata=0, err=0, wait counter=0. Memory array not cleared.
//  FSM: IDLE --accept--> (WAIT_STATES>0 ? WAIT : ACCESS); WAIT --cnt==1--> ACCESS; ACCESS --> IDLE.
//   - Accept edge: latch RW/Address/wdata/be; cnt <= WAIT_STATES.
//   - WAIT: cnt decrements each edge; ready=0.
//   - ACCESS: ready=0; the memory op is performed on the edge leaving ACCESS.
//     Write: byte i updated iff be[i]. be=0 completes with no change.
//     Read: rdata <= mem[addr], full word; be ignored.
//   - rvalid=1 (read) for exactly the first IDLE cycle after ACCESS; ready=1 in that same cycle.
//  Latency: acceptance edge E0 -> rvalid high in the cycle after edge E0+WAIT_STATES+1.
//   Continuous req: one transaction per WAIT_STATES+2 cycles.
//  Inputs outside IDLE are ignored; req needs no hold after acceptance.
//  Back-to-back write then read of the same address returns the new data (write done before read accepted).
//  Reset mid-operation: transaction aborted; a write not yet at its ACCESS edge never reaches memory.
//   No rvalid is produced. Reset on the ACCESS edge wins: no write, no rvalid.
//  Address >= DEPTH without range check: index = Address mod 2**ceil(log2(DEPTH)) if in range; otherwise undefined data.
// CONFIGURATION
//  `define DMEM_RANGE_CHK_EN
//   With: Address >= DEPTH -> write suppressed; read returns rdata=0.
//    err=1 for one cycle, aligned with rvalid (reads) or with the return to IDLE (writes).
//   Without: err tied 0; no comparator logic.
// TESTING
//  1 reset, WAIT_STATES=0: after reset, ready=1, rvalid=0, rdata=0; req=0 for 10 cycles -> outputs unchanged.
//  2 write 0xBEEF @0x005 be=11, then read @0x005 -> rvalid pulses 2 cycles after read acceptance, rdata=0xBEEF.
//  3 byte lanes: write 0xBEEF, then write 0x1234 be=01, read -> 0xBE34. Write be=00, read -> 0xBE34.
//  4 WAIT_STATES=3: read accepted at E0 -> ready low 4 cycles, rvalid in cycle after E0+4.
//    Continuous req -> accept every 5 cycles.
//  5 reset asserted during WAIT of a write 0xAAAA @0x010 (old 0x5555) -> read @0x010 = 0x5555, no rvalid from aborted op.
//  6 DMEM_RANGE_CHK_EN, DEPTH=3000: write @3000 then read @3000 -> err pulses both times, rdata=0.
//    Word @(3000 mod 4096)-aliased locations unchanged.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
//   Single-port data memory for the MEM stage with a req/ready handshake,
//   byte-lane writes and a fixed number of programmable wait states.
//   One transaction in flight; reads return through a one-cycle rvalid pulse.
//
// Parameters
//   DATA_WIDTH   word width in bits (multiple of 8)
//   ADDR_WIDTH   word-address width
//   DEPTH        number of words, 1 .. 2**ADDR_WIDTH
//   WAIT_STATES  extra busy cycles per access, 0 .. 15
//
// Ports
//   clock    in   single clock, posedge
//   reset    in   synchronous, active-high
//   req      in   request, accepted on an edge where req && ready
//   RW       in   1 = read, 0 = write (sampled at acceptance)
//   Address  in   word address (sampled at acceptance)
//   wdata    in   write data (sampled at acceptance)
//   be       in   byte enables, bit i -> wdata[8i+7:8i] (sampled at acceptance)
//   ready    out  high only in IDLE
//   rvalid   out  one-cycle pulse when rdata holds a completed read
//   rdata    out  registered read data, held until the next read completes
//   err      out  out-of-range flag, pulses with completion
//
// Optional feature: define DMEM_RANGE_CHK_EN to enable the address range
// check (writes >= DEPTH suppressed, reads >= DEPTH return 0, err pulses).
// Without it err is constant 0 and no comparator exists.

module data_mem_ctrl #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned DEPTH       = 4096,
  parameter int unsigned WAIT_STATES = 0,
  localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  RW,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [BE_WIDTH-1:0]   be,
  output logic                  ready,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS
  } state_t;

  state_t                state, state_n;
  logic [3:0]            cnt;
  logic                  accept;
  logic                  in_range;

  logic                  rw_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BE_WIDTH-1:0]   be_q;
  logic [IDX_W-1:0]      idx;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign accept = (state == S_IDLE) && req;
  // Addresses beyond DEPTH alias modulo 2**IDX_W when no range check is built.
  assign idx    = addr_q[IDX_W-1:0];

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (req) begin
          state_n = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd1) begin
          state_n = S_ACCESS;
        end
      end
      S_ACCESS: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    ready = (state == S_IDLE);
  end

  // Request operands, captured only at acceptance
  always_ff @(posedge clock) begin
    if (accept) begin
      rw_q    <= RW;
      addr_q  <= Address;
      wdata_q <= wdata;
      be_q    <= be;
    end
  end

  // Wait counter, read return path
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt    <= '0;
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= 1'b0;
      if (accept) begin
        cnt <= 4'(WAIT_STATES);
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (state == S_ACCESS && rw_q) begin
        rvalid <= 1'b1;
        rdata  <= in_range ? mem[idx] : '0;
      end
    end
  end

  // Memory write on the edge leaving ACCESS; reset on that edge suppresses it
  always_ff @(posedge clock) begin
    if (!reset && state == S_ACCESS && !rw_q && in_range) begin
      for (int unsigned i = 0; i < BE_WIDTH; i++) begin
        if (be_q[i]) begin
          mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

`ifdef DMEM_RANGE_CHK_EN
  assign in_range = ({1'b0, addr_q} < (ADDR_WIDTH + 1)'(DEPTH));

  // err rides along with the completion cycle of both reads and writes
  always_ff @(posedge clock) begin
    if (reset) begin
      err <= 1'b0;
    end else begin
      err <= (state == S_ACCESS) && !in_range;
    end
  end
`else
  assign in_range = 1'b1;
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

  logic        clock = 1'b0;
  logic        rst0 = 1'b1, rst3 = 1'b1;
  logic        req0 = 1'b0, req3 = 1'b0;
  logic        rw = 1'b0;
  logic [11:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [1:0]  be = '0;

  logic        rdy0, rv0, err0, rdy3, rv3, err3;
  logic [15:0] rd0, rd3;

  int unsigned cyc = 0;
  int unsigned tests = 0;
  int unsigned fails = 0;

  typedef struct {
    logic        rd;
    logic [15:0] data;
    logic        err;
    int unsigned cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q3[$];
  logic prev_rdy[2] = '{1'b1, 1'b1};
  logic prev_rst[2] = '{1'b1, 1'b1};

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  data_mem_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .DEPTH(3000), .WAIT_STATES(0)) u0 (
    .clock(clock), .reset(rst0), .req(req0), .RW(rw), .Address(addr),
    .wdata(wdata), .be(be), .ready(rdy0), .rvalid(rv0), .rdata(rd0), .err(err0)
  );

  data_mem_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .DEPTH(4096), .WAIT_STATES(3)) u3 (
    .clock(clock), .reset(rst3), .req(req3), .RW(rw), .Address(addr),
    .wdata(wdata), .be(be), .ready(rdy3), .rvalid(rv3), .rdata(rd3), .err(err3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: a rising ready marks a completion (rvalid distinguishes reads).
  task automatic mon(input int d, input logic rdy, input logic rv, input logic er,
                     input logic [15:0] rd, input logic rst_now);
    exp_t e;
    logic empty;
    if (prev_rst[d]) begin
      if (!prev_rdy[d] && rdy) chk($sformatf("dut%0d_no_rvalid_after_abort", d), 32'(rv), 32'd0);
    end else if (!prev_rdy[d] && rdy) begin
      empty = 1'b0;
      if (d == 0) begin
        if (q0.size() == 0) empty = 1'b1; else e = q0.pop_front();
      end else begin
        if (q3.size() == 0) empty = 1'b1; else e = q3.pop_front();
      end
      if (empty) begin
        chk($sformatf("dut%0d_unexpected_completion", d), 32'd1, 32'd0);
      end else begin
        chk($sformatf("dut%0d_kind", d), 32'(rv), 32'(e.rd));
        chk($sformatf("dut%0d_latency_cycle", d), cyc, e.cyc);
        chk($sformatf("dut%0d_err", d), 32'(er), 32'(e.err));
        if (e.rd) chk($sformatf("dut%0d_rdata", d), 32'(rd), 32'(e.data));
      end
    end else if (rv) begin
      chk($sformatf("dut%0d_spurious_rvalid", d), 32'(rv), 32'd0);
    end
    prev_rdy[d] = rdy;
    prev_rst[d] = rst_now;
  endtask

  always @(negedge clock) mon(0, rdy0, rv0, err0, rd0, rst0);
  always @(negedge clock) mon(1, rdy3, rv3, err3, rd3, rst3);

  task automatic push(input int d, input logic r, input logic [15:0] ed, input logic ee,
                      input int unsigned ec);
    exp_t e;
    e.rd = r; e.data = ed; e.err = ee; e.cyc = ec;
    if (d == 0) q0.push_back(e); else q3.push_back(e);
  endtask

  // All stimulus runs aligned to #1 after a posedge.
  task automatic wait_ready(input int d);
    int n = 0;
    while (!((d == 0) ? rdy0 : rdy3) && n < 50) begin
      @(posedge clock); #1; n++;
    end
    if (n >= 50) chk($sformatf("dut%0d_ready_timeout", d), 32'd1, 32'd0);
  endtask

  // Completion is visible after edge (accept + WS + 1); accept edge is cyc+1.
  task automatic op(input int d, input logic r, input logic [11:0] a, input logic [15:0] wd,
                    input logic [1:0] b, input logic push_it, input logic [15:0] ed,
                    input logic ee);
    wait_ready(d);
    rw = r; addr = a; wdata = wd; be = b;
    if (d == 0) req0 = 1'b1; else req3 = 1'b1;
    if (push_it) push(d, r, ed, ee, cyc + 2 + ((d == 0) ? 0 : 3));
    @(posedge clock); #1;
    req0 = 1'b0; req3 = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"},  32'(rdy0), 32'd1);
    chk({tag, "_rvalid"}, 32'(rv0),  32'd0);
    chk({tag, "_rdata"},  32'(rd0),  32'd0);
    chk({tag, "_err"},    32'(err0), 32'd0);
  endtask

  initial begin
    int unsigned c;
    int n;

    repeat (3) @(posedge clock);
    #1;
    rst0 = 1'b0; rst3 = 1'b0;

    // Reset state, then quiet idle
    chk_idle("rst0");
    chk("rst3_ready",  32'(rdy3), 32'd1);
    chk("rst3_rvalid", 32'(rv3),  32'd0);
    chk("rst3_rdata",  32'(rd3),  32'd0);
    repeat (10) begin @(posedge clock); #1; end
    chk_idle("idle10");

    // Full-word write and readback, no wait states
    op(0, 1'b0, 12'h005, 16'hBEEF, 2'b11, 1'b1, 16'h0000, 1'b0);
    op(0, 1'b1, 12'h005, 16'h0000, 2'b00, 1'b1, 16'hBEEF, 1'b0);

    // Byte lanes: low lane only, then no lanes
    op(0, 1'b0, 12'h005, 16'h1234, 2'b01, 1'b1, 16'h0000, 1'b0);
    op(0, 1'b1, 12'h005, 16'h0000, 2'b11, 1'b1, 16'hBE34, 1'b0);
    op(0, 1'b0, 12'h005, 16'hFFFF, 2'b00, 1'b1, 16'h0000, 1'b0);
    op(0, 1'b1, 12'h005, 16'h0000, 2'b00, 1'b1, 16'hBE34, 1'b0);
    op(0, 1'b0, 12'h005, 16'hA5C3, 2'b10, 1'b1, 16'h0000, 1'b0);
    op(0, 1'b1, 12'h005, 16'h0000, 2'b01, 1'b1, 16'hA534, 1'b0);

    // Reset landing on the ACCESS edge: write must not happen, no completion
    op(0, 1'b0, 12'h020, 16'h1111, 2'b11, 1'b1, 16'h0000, 1'b0);
    op(0, 1'b0, 12'h020, 16'hDEAD, 2'b11, 1'b0, 16'h0000, 1'b0);
    rst0 = 1'b1;
    @(posedge clock); #1;
    rst0 = 1'b0;
    op(0, 1'b1, 12'h020, 16'h0000, 2'b11, 1'b1, 16'h1111, 1'b0);

    // Three wait states: write then read (latency via expected cycle)
    op(1, 1'b0, 12'h100, 16'h0101, 2'b11, 1'b1, 16'h0000, 1'b0);
    op(1, 1'b0, 12'h101, 16'h0202, 2'b11, 1'b1, 16'h0000, 1'b0);
    op(1, 1'b0, 12'h102, 16'h0303, 2'b11, 1'b1, 16'h0000, 1'b0);
    op(1, 1'b1, 12'h101, 16'h0000, 2'b11, 1'b1, 16'h0202, 1'b0);

    // Continuous req: acceptances every 5 cycles, address changed between them
    wait_ready(1);
    c = cyc;
    rw = 1'b1; addr = 12'h100; req3 = 1'b1;
    push(1, 1'b1, 16'h0101, 1'b0, c + 5);
    repeat (5) begin @(posedge clock); #1; end
    addr = 12'h101;
    push(1, 1'b1, 16'h0202, 1'b0, c + 10);
    repeat (5) begin @(posedge clock); #1; end
    addr = 12'h102;
    push(1, 1'b1, 16'h0303, 1'b0, c + 15);
    repeat (5) begin @(posedge clock); #1; end
    req3 = 1'b0;

    // Reset during WAIT of a write: memory keeps the old value
    op(1, 1'b0, 12'h010, 16'h5555, 2'b11, 1'b1, 16'h0000, 1'b0);
    op(1, 1'b0, 12'h010, 16'hAAAA, 2'b11, 1'b0, 16'h0000, 1'b0);
    @(posedge clock); #1;
    rst3 = 1'b1;
    @(posedge clock); #1;
    rst3 = 1'b0;
    op(1, 1'b1, 12'h010, 16'h0000, 2'b11, 1'b1, 16'h5555, 1'b0);

`ifdef DMEM_RANGE_CHK_EN
    // Out-of-range on DEPTH=3000: write dropped, read returns 0, err pulses
    op(0, 1'b0, 12'h000, 16'h1111, 2'b11, 1'b1, 16'h0000, 1'b0);
    op(0, 1'b0, 12'd952, 16'h2222, 2'b11, 1'b1, 16'h0000, 1'b0);
    op(0, 1'b0, 12'd2999, 16'h3333, 2'b11, 1'b1, 16'h0000, 1'b0);
    op(0, 1'b0, 12'd3000, 16'h9999, 2'b11, 1'b1, 16'h0000, 1'b1);
    op(0, 1'b1, 12'd3000, 16'h0000, 2'b11, 1'b1, 16'h0000, 1'b1);
    op(0, 1'b1, 12'h000, 16'h0000, 2'b11, 1'b1, 16'h1111, 1'b0);
    op(0, 1'b1, 12'd952, 16'h0000, 2'b11, 1'b1, 16'h2222, 1'b0);
    op(0, 1'b1, 12'd2999, 16'h0000, 2'b11, 1'b1, 16'h3333, 1'b0);
`endif

    // Drain scoreboards
    n = 0;
    while ((q0.size() != 0 || q3.size() != 0) && n < 100) begin
      @(posedge clock); #1; n++;
    end
    chk("sb0_drained", q0.size(), 32'd0);
    chk("sb3_drained", q3.size(), 32'd0);
    repeat (3) begin @(posedge clock); #1; end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
